// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the decoder. Holds the fetch PC, issues
//   in-order word requests to instruction memory, buffers returned words with
//   their PCs in a small FIFO and hands them to the decoder. A redirect
//   flushes the buffer and discards every response still in flight.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   imem_req_*         request channel (valid/ready, word address)
//   imem_resp_*        in-order response channel, no backpressure
//   redirect_*         control-flow redirect and its target
//   inst_valid/ready   decoder handshake
//   inst_out, pc_out   head instruction and its PC (NOP / 0 when empty)
//   misalign_err       sticky: a redirect target was not word aligned
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        misalign_err
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc_r;
    logic [31:0]   resp_pc_r;
    logic [31:0]   inst_mem_r [FIFO_DEPTH];
    logic [31:0]   pc_mem_r   [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] drop_cnt_r;
    logic          misalign_r;

    logic [CW:0]   credit_used_s;
    logic          accept_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic [31:0]   target_s;
    logic [CW-1:0] inflight_next_s;
    logic [CW-1:0] count_next_s;

    // Credit check, handshake qualifiers and next-count arithmetic.
    // Outstanding requests plus buffered words never exceed the buffer size,
    // so every accepted response is guaranteed a free slot.
    always_comb begin
        credit_used_s   = {1'b0, inflight_r} + {1'b0, count_r};
        imem_req_valid  = !rst && !redirect_valid && (credit_used_s < DEPTH_W);
        accept_s        = imem_req_valid && imem_req_ready;
        drop_s          = imem_resp_valid && (drop_cnt_r != {CW{1'b0}});
        push_s          = imem_resp_valid && !drop_s && !redirect_valid;
        pop_s           = inst_valid && inst_ready && !redirect_valid;
        full_s          = (count_r == DEPTH_W[CW-1:0]);
        target_s        = {redirect_pc[31:2], 2'b00};
        inflight_next_s = inflight_r + CW'(accept_s) - CW'(imem_resp_valid);
        count_next_s    = count_r + CW'(push_s) - CW'(pop_s);
    end

    // Decoder-facing view of the FIFO head.
    always_comb begin
        inst_valid = (count_r != {CW{1'b0}});
        if (inst_valid) begin
            inst_out = inst_mem_r[rd_ptr_r];
            pc_out   = pc_mem_r[rd_ptr_r];
        end else begin
            inst_out = NOP;
            pc_out   = 32'h0000_0000;
        end
    end

    assign imem_req_addr = fetch_pc_r;
    assign misalign_err  = misalign_r;

    // PCs, FIFO pointers, request/drop accounting and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            inflight_r <= {CW{1'b0}};
            drop_cnt_r <= {CW{1'b0}};
            misalign_r <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc_r <= target_s;
            resp_pc_r  <= target_s;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            inflight_r <= inflight_next_s;
            // Everything still outstanding after this cycle's response
            // (which is itself discarded) belongs to the old path. Requests
            // already marked for dropping are part of that same total.
            drop_cnt_r <= inflight_r - CW'(imem_resp_valid);
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_r <= 1'b1;
            end
        end else begin
            inflight_r <= inflight_next_s;
            count_r    <= count_next_s;
            if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (drop_s) begin
                drop_cnt_r <= drop_cnt_r - CW'(1'b1);
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + 32'd4;
                wr_ptr_r  <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
        end
    end

    // FIFO storage; contents are only meaningful below count_r, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            inst_mem_r[wr_ptr_r] <= imem_resp_data;
            pc_mem_r[wr_ptr_r]   <= resp_pc_r;
        end
    end

    fetch_unit_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .full (full_s)
    );
endmodule

// ---------------------------------------------------------------------------
// fetch_unit_chk
//   Checker: a response must never be pushed into a full buffer.
// Ports
//   clk, rst   clock and reset of the checked block
//   push, full buffer push strobe and full status
// ---------------------------------------------------------------------------
module fetch_unit_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic full
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full))
        else $error("fetch_unit: push into full instruction buffer");
endmodule
